// File: rtl/tff_sync_counter.sv
// tff_sync_counter: synchronous modulo-MOD up/down counter built from toggle flip-flops.
//
// Each bit carries its own toggle enable t[i] = q[i] ^ q_next[i] and updates as
// q[i] <= q[i] ^ t[i]. Provides a combinational terminal count (tc) and a registered
// wrap pulse that is coincident with the wrapped count value.
//
// Optional feature macro: TFFC_GRAY_OUT_EN
//   defined   -> adds registered output gray = Gray code of q, updated on the same edge.
//   undefined -> no gray port and no gray registers.
module tff_sync_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MOD   = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
`ifdef TFFC_GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0] gray
`endif
);

    // Largest legal count. For MOD == 2**WIDTH this is all ones, so the up-step wrap
    // is plain binary overflow and no WIDTH+1 compare is ever needed.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    // Elaboration-time guard on the configuration range.
    if (WIDTH == 0 || WIDTH > 16) begin : g_bad_width
        $error("tff_sync_counter: WIDTH must be 1..16");
    end
    if (MOD < 2 || MOD > (32'd1 << WIDTH)) begin : g_bad_mod
        $error("tff_sync_counter: MOD must be 2..2**WIDTH");
    end

    logic             at_max;
    logic             at_zero;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] inc_val;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t;
    logic             step_wrap;

    // Boundary detection on the current count.
    always_comb begin
        at_max  = (q == MAX_VAL);
        at_zero = (q == '0);
    end

    // Clamp out-of-range load values to the top of the count range so q never
    // leaves 0..MOD-1.
    always_comb begin
        load_clamped = load_val;
        if (load_val > MAX_VAL) begin
            load_clamped = MAX_VAL;
        end
    end

    // Modulo increment and decrement candidates.
    always_comb begin
        inc_val = at_max  ? '0      : (q + ONE);
        dec_val = at_zero ? MAX_VAL : (q - ONE);
    end

    // Next-state selection: load has priority over en, otherwise hold.
    always_comb begin
        q_next = q;
        if (load) begin
            q_next = load_clamped;
        end else if (en) begin
            q_next = up ? inc_val : dec_val;
        end
    end

    // Per-bit toggle enables; all zero whenever the count holds.
    always_comb begin
        t = q ^ q_next;
    end

    // A step that crosses the boundary in the selected direction. This is both the
    // terminal count and the condition that launches the wrap pulse.
    always_comb begin
        step_wrap = en & ~load & (up ? at_max : at_zero);
    end

    assign tc = step_wrap;

    // Toggle flip-flop array holding the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                q[i] <= q[i] ^ t[i];
            end
        end
    end

    // Wrap pulse register, high exactly in the cycle q shows the wrapped value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= step_wrap;
        end
    end

`ifdef TFFC_GRAY_OUT_EN
    logic [WIDTH-1:0] gray_next;

    // Gray code of the next count so gray lines up with q on the same edge.
    always_comb begin
        gray_next = q_next ^ (q_next >> 1);
    end

    // Gray output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gray <= '0;
        end else begin
            gray <= gray_next;
        end
    end
`endif

endmodule
